// File: rtl/tdm_demux4.sv
// tdm_demux4 -- four-channel time-division demultiplexer.
//
// Receive end of a slot-serial link whose sender cycles slots 0..3. Frame
// alignment comes from a sync strobe on slot 0. Captured slots are held in
// shadow registers and transferred to the parallel outputs as a group when
// the final slot of a frame arrives.
//
// Build option: TDM_DEMUX_PARITY_EN
//   defined   -> 5-slot frame; slot 4 carries the XOR of the four data words.
//                The outputs update only when the parity word matches.
//   undefined -> 4-slot frame; par_err is tied low.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   en           slot strobe; din and sync are sampled only when en=1
//   sync         frame marker, expected high on slot 0
//   din          slot data
//   out1..out4   registered channel words for slots 0..3
//   frame_valid  one-cycle pulse when out1..out4 update
//   locked       high while frame alignment is held
//   slot         index of the next slot to capture (0 while hunting)
//   sync_err     one-cycle pulse on a sync seen away from slot 0
//   par_err      one-cycle pulse on a parity mismatch
//
// State table
//   state | meaning
//   HUNT  | no alignment; waiting for en&sync to start a frame
//   LOCK  | aligned; capturing slots and counting frames that lack sync
module tdm_demux4 #(
    parameter int W        = 1,
    parameter int MISS_MAX = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         sync,
    input  logic [W-1:0] din,
    output logic [W-1:0] out1,
    output logic [W-1:0] out2,
    output logic [W-1:0] out3,
    output logic [W-1:0] out4,
    output logic         frame_valid,
    output logic         locked,
`ifdef TDM_DEMUX_PARITY_EN
    output logic [2:0]   slot,
`else
    output logic [1:0]   slot,
`endif
    output logic         sync_err,
    output logic         par_err
);

`ifdef TDM_DEMUX_PARITY_EN
    localparam int SW    = 3;
    localparam int NSLOT = 5;
`else
    localparam int SW    = 2;
    localparam int NSLOT = 4;
`endif
    // The final slot goes straight to the outputs, so it needs no shadow.
    localparam int NSH = NSLOT - 1;
    localparam logic [SW-1:0] LAST     = SW'(NSLOT - 1);
    localparam logic [2:0]    MISS_TOP = 3'(MISS_MAX - 1);

    typedef enum logic {HUNT, LOCK} state_t;

    state_t          state, state_nx;
    logic [SW-1:0]   slot_nx;
    logic [2:0]      miss, miss_nx;
    logic [W-1:0]    shadow    [NSH];
    logic [W-1:0]    shadow_nx [NSH];
    logic [W-1:0]    out1_nx, out2_nx, out3_nx, out4_nx;
    logic            fv_nx, se_nx;
`ifdef TDM_DEMUX_PARITY_EN
    logic            pe_nx;
    logic [W-1:0]    par_calc;
`endif

    always_comb begin
        state_nx  = state;
        slot_nx   = slot;
        miss_nx   = miss;
        shadow_nx = shadow;
        out1_nx   = out1;
        out2_nx   = out2;
        out3_nx   = out3;
        out4_nx   = out4;
        fv_nx     = 1'b0;
        se_nx     = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        pe_nx     = 1'b0;
        par_calc  = shadow[0] ^ shadow[1] ^ shadow[2] ^ shadow[3];
`endif
        if (en) begin
            if (state == HUNT) begin
                if (sync) begin
                    shadow_nx[0] = din;
                    slot_nx      = SW'(1);
                    state_nx     = LOCK;
                end
            end else if (slot != '0) begin
                if (sync) begin
                    // Sync in the wrong place: realign on this word.
                    se_nx        = 1'b1;
                    shadow_nx[0] = din;
                    slot_nx      = SW'(1);
                end else if (slot == LAST) begin
                    slot_nx = '0;
`ifdef TDM_DEMUX_PARITY_EN
                    if (par_calc == din) begin
                        out1_nx = shadow[0];
                        out2_nx = shadow[1];
                        out3_nx = shadow[2];
                        out4_nx = shadow[3];
                        fv_nx   = 1'b1;
                    end else begin
                        pe_nx   = 1'b1;
                    end
`else
                    out1_nx = shadow[0];
                    out2_nx = shadow[1];
                    out3_nx = shadow[2];
                    out4_nx = din;
                    fv_nx   = 1'b1;
`endif
                end else begin
                    for (int i = 1; i < NSH; i++) begin
                        if (slot == i[SW-1:0]) shadow_nx[i] = din;
                    end
                    slot_nx = slot + SW'(1);
                end
            end else begin
                if (sync) begin
                    miss_nx      = '0;
                    shadow_nx[0] = din;
                    slot_nx      = SW'(1);
                end else if (miss == MISS_TOP) begin
                    // Too many frames without sync: drop lock, discard word.
                    state_nx = HUNT;
                    slot_nx  = '0;
                    miss_nx  = '0;
                end else begin
                    miss_nx      = miss + 3'd1;
                    shadow_nx[0] = din;
                    slot_nx      = SW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            slot        <= '0;
            miss        <= '0;
            for (int i = 0; i < NSH; i++) shadow[i] <= '0;
            out1        <= '0;
            out2        <= '0;
            out3        <= '0;
            out4        <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_nx;
            slot        <= slot_nx;
            miss        <= miss_nx;
            shadow      <= shadow_nx;
            out1        <= out1_nx;
            out2        <= out2_nx;
            out3        <= out3_nx;
            out4        <= out4_nx;
            frame_valid <= fv_nx;
            sync_err    <= se_nx;
        end
    end

`ifdef TDM_DEMUX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_err <= 1'b0;
        else        par_err <= pe_nx;
    end
`else
    assign par_err = 1'b0;
`endif

    assign locked = (state == LOCK);

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 with W=1, MISS_MAX=2. Expected values are
// hand-computed per step.
module tb_tdm_demux4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic sync = 1'b0;
    logic din = 1'b0;
    logic out1, out2, out3, out4;
    logic frame_valid, locked, sync_err, par_err;
`ifdef TDM_DEMUX_PARITY_EN
    logic [2:0] slot;
`else
    logic [1:0] slot;
`endif

    int total = 0;
    int bad   = 0;

    tdm_demux4 #(.W(1), .MISS_MAX(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .din(din),
        .out1(out1), .out2(out2), .out3(out3), .out4(out4),
        .frame_valid(frame_valid), .locked(locked), .slot(slot),
        .sync_err(sync_err), .par_err(par_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one slot, clock it, and sample 1 time unit after the edge.
    task automatic cyc(input logic e, input logic s, input logic d);
        en = e; sync = s; din = d;
        @(posedge clk);
        #1;
    endtask

    // Check outputs {out1..out4}, frame_valid, slot, locked together.
    task automatic st(input string tag, input logic [3:0] o, input logic fv,
                      input logic [2:0] sl, input logic lk);
        chk({tag, ".out"}, {28'd0, out1, out2, out3, out4}, {28'd0, o});
        chk({tag, ".fv"}, {31'd0, frame_valid}, {31'd0, fv});
        chk({tag, ".slot"}, 32'(slot), {29'd0, sl});
        chk({tag, ".locked"}, {31'd0, locked}, {31'd0, lk});
    endtask

    task automatic gap2(input string tag, input logic [3:0] o, input logic [2:0] sl);
        cyc(0, 0, 1); st(tag, o, 0, sl, 1);
        cyc(0, 1, 0); st(tag, o, 0, sl, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        st("reset", 4'b0000, 0, 0, 0);
        chk("reset.sync_err", {31'd0, sync_err}, 32'd0);
        chk("reset.par_err", {31'd0, par_err}, 32'd0);
        rst_n = 1'b1;

`ifdef TDM_DEMUX_PARITY_EN
        cyc(1, 1, 1); st("p1.s0", 4'b0000, 0, 1, 1);
        cyc(1, 0, 0);
        cyc(1, 0, 1);
        cyc(1, 0, 1); st("p1.s3", 4'b0000, 0, 4, 1);
        cyc(1, 0, 1); st("p1.done", 4'b1011, 1, 0, 1);
        chk("p1.par_err", {31'd0, par_err}, 32'd0);
        cyc(1, 1, 1);
        cyc(1, 0, 0);
        cyc(1, 0, 1);
        cyc(1, 0, 1);
        cyc(1, 0, 0); st("p2.bad", 4'b1011, 0, 0, 1);
        chk("p2.par_err", {31'd0, par_err}, 32'd1);
        cyc(0, 0, 0);
        chk("p2.par_err_low", {31'd0, par_err}, 32'd0);
`else
        // HUNT ignores en without sync.
        cyc(1, 0, 1); st("hunt.ignore", 4'b0000, 0, 0, 0);

        // Basic frame 0,1,1,1.
        cyc(1, 1, 0); st("b.s0", 4'b0000, 0, 1, 1);
        cyc(1, 0, 1); st("b.s1", 4'b0000, 0, 2, 1);
        cyc(1, 0, 1); st("b.s2", 4'b0000, 0, 3, 1);
        cyc(1, 0, 1); st("b.done", 4'b0111, 1, 0, 1);
        cyc(0, 0, 0); st("b.after", 4'b0111, 0, 0, 1);

        // Frames with two-cycle en gaps between slots.
        cyc(1, 1, 1); st("g1.s0", 4'b0111, 0, 1, 1);
        gap2("g1.gapa", 4'b0111, 1);
        cyc(1, 0, 0);
        gap2("g1.gapb", 4'b0111, 2);
        cyc(1, 0, 0);
        gap2("g1.gapc", 4'b0111, 3);
        cyc(1, 0, 1); st("g1.done", 4'b1001, 1, 0, 1);
        gap2("g2.gap0", 4'b1001, 0);
        cyc(1, 1, 0);
        gap2("g2.gapa", 4'b1001, 1);
        cyc(1, 0, 1);
        gap2("g2.gapb", 4'b1001, 2);
        cyc(1, 0, 0);
        gap2("g2.gapc", 4'b1001, 3);
        cyc(1, 0, 0); st("g2.done", 4'b0100, 1, 0, 1);

        // Misplaced sync at slot 2 realigns on that word.
        cyc(1, 1, 1);
        cyc(1, 0, 0);
        cyc(1, 1, 1); st("ms.realign", 4'b0100, 0, 1, 1);
        chk("ms.sync_err", {31'd0, sync_err}, 32'd1);
        cyc(1, 0, 0); st("ms.s1", 4'b0100, 0, 2, 1);
        chk("ms.sync_err_low", {31'd0, sync_err}, 32'd0);
        cyc(1, 0, 1);
        cyc(1, 0, 0); st("ms.done", 4'b1010, 1, 0, 1);

        // Two frames with no sync at slot 0 drop lock.
        cyc(1, 0, 1); st("miss1.s0", 4'b1010, 0, 1, 1);
        cyc(1, 0, 1);
        cyc(1, 0, 1);
        cyc(1, 0, 0); st("miss1.done", 4'b1110, 1, 0, 1);
        cyc(1, 0, 1); st("miss2.drop", 4'b1110, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 1); st("hunt.idle", 4'b1110, 0, 0, 0);
        end
        chk("hunt.sync_err", {31'd0, sync_err}, 32'd0);

        // Relock; a synced frame clears the miss count.
        cyc(1, 1, 0); st("relock", 4'b1110, 0, 1, 1);
        cyc(1, 0, 0);
        cyc(1, 0, 1);
        cyc(1, 0, 1); st("rl.done", 4'b0011, 1, 0, 1);
        cyc(1, 0, 0);
        cyc(1, 0, 1);
        cyc(1, 0, 1);
        cyc(1, 0, 1); st("rl.miss1", 4'b0111, 1, 0, 1);
        cyc(1, 1, 1);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        cyc(1, 0, 0); st("rl.synced", 4'b1000, 1, 0, 1);
        cyc(1, 0, 0); st("rl.miss_cleared", 4'b1000, 0, 1, 1);

        // Asynchronous reset mid-frame, checked before the next edge.
        cyc(1, 0, 1);
        #3;
        rst_n = 1'b0;
        #1;
        st("areset", 4'b0000, 0, 0, 0);
        chk("areset.sync_err", {31'd0, sync_err}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1, 0, 1); st("areset.hunt", 4'b0000, 0, 0, 0);

        // Back-to-back frames with en tied high: no bubble.
        cyc(1, 1, 1);
        cyc(1, 0, 1);
        cyc(1, 0, 0);
        cyc(1, 0, 1); st("bb1.done", 4'b1101, 1, 0, 1);
        cyc(1, 1, 0); st("bb2.s0", 4'b1101, 0, 1, 1);
        cyc(1, 0, 0);
        cyc(1, 0, 1);
        cyc(1, 0, 1); st("bb2.done", 4'b0011, 1, 0, 1);
        chk("par_err.tied", {31'd0, par_err}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
